cr_huf_comp_sc: RTL and testbench



---
 rtl/cr_huf_comp_sc_pkg.sv | 51 +++++
 rtl/cr_huf_comp_sc_fifo.sv | 64 ++++++
 rtl/cr_huf_comp_sc.sv | 216 +++++++++++++++++++++
 tb/tb_cr_huf_comp_sc.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_comp_sc_pkg.sv
// Shared types for the Huffman symbol collapser: entry/word structs, eob tag and run limit.
// CREOLE_HC_SEQID_WIDTH sizes the block sequence id and defaults to 8 when not provided.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_compPKG;

  localparam int SC_DAT_WIDTH   = 10;
  localparam int SC_CNT_WIDTH   = 3;
  localparam int SC_CNTRL_WIDTH = 1;
  localparam int SC_SEQID_WIDTH = `CREOLE_HC_SEQID_WIDTH;

  // Largest run a single entry can carry; longer runs split into several entries.
  localparam logic [SC_CNT_WIDTH-1:0] SC_MAX_CNT = '1;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    LAST      = 2'd1,
    PASS_THRU = 2'd2,
    PASS_LAST = 2'd3
  } e_pipe_eob;

  typedef struct packed {
    logic [SC_DAT_WIDTH-1:0] sym;
    logic [SC_CNT_WIDTH-1:0] cnt;
  } sc_entry_t;

  typedef struct packed {
    logic [3:0]                vld;
    sc_entry_t [3:0]           entry;
    logic [SC_CNTRL_WIDTH-1:0] meta;
    logic [SC_SEQID_WIDTH-1:0] seq_id;
    e_pipe_eob                 eob;
  } sc_word_t;

  function automatic sc_word_t sc_pack_word(input logic [3:0]                vld,
                                            input sc_entry_t [3:0]           ent,
                                            input logic [SC_CNTRL_WIDTH-1:0] meta,
                                            input logic [SC_SEQID_WIDTH-1:0] seq_id,
                                            input e_pipe_eob                 eob);
    sc_word_t w;
    w.vld    = vld;
    w.entry  = ent;
    w.meta   = meta;
    w.seq_id = seq_id;
    w.eob    = eob;
    return w;
  endfunction

endpackage

// File: rtl/cr_huf_comp_sc_fifo.sv
// First-word-fall-through FIFO of packed collapser words with two push ports and one pop.
// push1 is only legal together with push0 and lands behind it.
module cr_huf_comp_sc_fifo
  import cr_huf_compPKG::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  sc_word_t      wdata0,
  input  logic          push1,
  input  sc_word_t      wdata1,
  input  logic          pop,
  output sc_word_t      rdata,
  output logic          not_empty,
  output logic [CW-1:0] free_cnt
);

  sc_word_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    n_push;
  logic          pop_eff;

  assign n_push    = {1'b0, push0} + {1'b0, push1};
  assign not_empty = (count != '0);
  assign pop_eff   = pop & not_empty;
  assign free_cnt  = CW'(DEPTH) - count;
  // Empty head reads as all zeros so the consumer sees clean outputs.
  assign rdata     = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= wdata0;
    if (push1) mem[wr_ptr + AW'(1)] <= wdata1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop_eff) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(n_push) - CW'(pop_eff);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (CW'(n_push) <= free_cnt)
        else $error("cr_huf_comp_sc_fifo: push without free space");
      assert (!(push1 && !push0))
        else $error("cr_huf_comp_sc_fifo: push1 without push0");
    end
  end
`endif

endmodule

// File: rtl/cr_huf_comp_sc.sv
// Symbol collapser: run-length collapses symbols into (sym, cnt) entries, packs four per word, buffers in a FIFO.
// Optional per-block statistics outputs are enabled by defining CR_HUF_COMP_SC_STATS_EN.
module cr_huf_comp_sc
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH   = SC_DAT_WIDTH,
  parameter int CNT_WIDTH   = SC_CNT_WIDTH,
  parameter int CNTRL_WIDTH = SC_CNTRL_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic [DAT_WIDTH-1:0]      in_sym,
  input  logic [CNTRL_WIDTH-1:0]    in_meta,
  input  logic [SC_SEQID_WIDTH-1:0] in_seq_id,
  input  e_pipe_eob                 in_eob,
  output logic                      sc_in_rdy,
  output logic [3:0]                sc_is_vld,
  output logic [DAT_WIDTH-1:0]      sc_is_sym0,
  output logic [DAT_WIDTH-1:0]      sc_is_sym1,
  output logic [DAT_WIDTH-1:0]      sc_is_sym2,
  output logic [DAT_WIDTH-1:0]      sc_is_sym3,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt0,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt1,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt2,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt3,
  output logic [CNTRL_WIDTH-1:0]    sc_is_meta,
  output logic [SC_SEQID_WIDTH-1:0] sc_is_seq_id,
  output e_pipe_eob                 sc_is_eob,
  output logic                      sc_is_not_empty,
  input  logic                      is_sc_rd
`ifdef CR_HUF_COMP_SC_STATS_EN
  ,
  output logic [19:0]               sc_stat_sym_cnt,
  output logic [15:0]               sc_stat_ent_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a symbol transfers on a clock edge where in_vld and sc_in_rdy are both high;
  // the head word leaves the FIFO on an edge where is_sc_rd and sc_is_not_empty are both high.
  logic accept;

  logic [DAT_WIDTH-1:0]      acc_sym, n_acc_sym;
  logic [CNT_WIDTH-1:0]      acc_cnt, n_acc_cnt;
  logic                      acc_vld, n_acc_vld;
  sc_entry_t [3:0]           pack_ent, n_pack_ent;
  logic [3:0]                pack_vld, n_pack_vld;
  logic [1:0]                lane_idx, n_lane;
  logic                      blk_open;
  logic [CNTRL_WIDTH-1:0]    blk_meta, cur_meta;
  logic [SC_SEQID_WIDTH-1:0] blk_seq, cur_seq;
  logic                      rdy_q;
  logic                      is_eob;
  logic [1:0]                n_close;

  logic                      push0, push1;
  sc_word_t                  word0, word1, head;
  logic [CW-1:0]             free_cnt, free_nxt;
  logic                      pop_eff;

  assign accept    = in_vld & sc_in_rdy;
  assign sc_in_rdy = rdy_q & ~rst;
  assign is_eob    = (in_eob != MIDDLE);
  // Tags come from the first symbol of the block, including when that symbol is the current one.
  assign cur_meta  = blk_open ? blk_meta : in_meta;
  assign cur_seq   = blk_open ? blk_seq  : in_seq_id;

  always_comb begin
    n_acc_sym  = acc_sym;
    n_acc_cnt  = acc_cnt;
    n_acc_vld  = acc_vld;
    n_pack_ent = pack_ent;
    n_pack_vld = pack_vld;
    n_lane     = lane_idx;
    push0      = 1'b0;
    push1      = 1'b0;
    word0      = '0;
    word1      = '0;
    n_close    = 2'd0;
    if (accept) begin
      if (acc_vld && (in_sym == acc_sym) && (acc_cnt != SC_MAX_CNT)) begin
        n_acc_cnt = acc_cnt + CNT_WIDTH'(1);
      end else begin
        if (acc_vld) begin
          n_pack_ent[n_lane] = '{sym: acc_sym, cnt: acc_cnt};
          n_pack_vld[n_lane] = 1'b1;
          n_close            = n_close + 2'd1;
          if (n_lane == 2'd3) begin
            push0      = 1'b1;
            word0      = sc_pack_word(n_pack_vld, n_pack_ent, cur_meta, cur_seq, MIDDLE);
            n_pack_ent = '0;
            n_pack_vld = '0;
            n_lane     = 2'd0;
          end else begin
            n_lane = n_lane + 2'd1;
          end
        end
        n_acc_sym = in_sym;
        n_acc_cnt = CNT_WIDTH'(1);
        n_acc_vld = 1'b1;
      end
      // End of block: flush the (always valid) accumulator and emit the closing word.
      if (is_eob) begin
        n_pack_ent[n_lane] = '{sym: n_acc_sym, cnt: n_acc_cnt};
        n_pack_vld[n_lane] = 1'b1;
        n_close            = n_close + 2'd1;
        if (push0) begin
          push1 = 1'b1;
          word1 = sc_pack_word(n_pack_vld, n_pack_ent, cur_meta, cur_seq, in_eob);
        end else begin
          push0 = 1'b1;
          word0 = sc_pack_word(n_pack_vld, n_pack_ent, cur_meta, cur_seq, in_eob);
        end
        n_acc_sym  = '0;
        n_acc_cnt  = '0;
        n_acc_vld  = 1'b0;
        n_pack_ent = '0;
        n_pack_vld = '0;
        n_lane     = 2'd0;
      end
    end
  end

  // Ready looks at next-cycle free space since one accepted input can push two words.
  assign pop_eff  = is_sc_rd & sc_is_not_empty;
  assign free_nxt = free_cnt - CW'(push0) - CW'(push1) + CW'(pop_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sym  <= '0;
      acc_cnt  <= '0;
      acc_vld  <= 1'b0;
      pack_ent <= '0;
      pack_vld <= '0;
      lane_idx <= '0;
      blk_open <= 1'b0;
      blk_meta <= '0;
      blk_seq  <= '0;
      rdy_q    <= 1'b1;
    end else begin
      acc_sym  <= n_acc_sym;
      acc_cnt  <= n_acc_cnt;
      acc_vld  <= n_acc_vld;
      pack_ent <= n_pack_ent;
      pack_vld <= n_pack_vld;
      lane_idx <= n_lane;
      rdy_q    <= (free_nxt >= CW'(2));
      if (accept) begin
        blk_open <= ~is_eob;
        blk_meta <= cur_meta;
        blk_seq  <= cur_seq;
      end
    end
  end

  cr_huf_comp_sc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0     (push0),
    .wdata0    (word0),
    .push1     (push1),
    .wdata1    (word1),
    .pop       (is_sc_rd),
    .rdata     (head),
    .not_empty (sc_is_not_empty),
    .free_cnt  (free_cnt)
  );

  assign sc_is_vld    = head.vld;
  assign sc_is_sym0   = head.entry[0].sym;
  assign sc_is_sym1   = head.entry[1].sym;
  assign sc_is_sym2   = head.entry[2].sym;
  assign sc_is_sym3   = head.entry[3].sym;
  assign sc_is_cnt0   = head.entry[0].cnt;
  assign sc_is_cnt1   = head.entry[1].cnt;
  assign sc_is_cnt2   = head.entry[2].cnt;
  assign sc_is_cnt3   = head.entry[3].cnt;
  assign sc_is_meta   = head.meta;
  assign sc_is_seq_id = head.seq_id;
  assign sc_is_eob    = head.eob;

`ifdef CR_HUF_COMP_SC_STATS_EN
  logic [19:0] sym_cnt, sym_base, sym_nxt;
  logic [15:0] ent_cnt, ent_base, ent_nxt;
  logic [16:0] ent_sum;
  logic        stat_clr;

  // Counts of a finished block stay visible for one cycle, then restart from zero.
  always_comb begin
    sym_base = stat_clr ? '0 : sym_cnt;
    ent_base = stat_clr ? '0 : ent_cnt;
    sym_nxt  = (accept && (sym_base != '1)) ? sym_base + 20'd1 : sym_base;
    ent_sum  = {1'b0, ent_base} + 17'(n_close);
    ent_nxt  = ent_sum[16] ? '1 : ent_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt  <= '0;
      ent_cnt  <= '0;
      stat_clr <= 1'b0;
    end else begin
      sym_cnt  <= sym_nxt;
      ent_cnt  <= ent_nxt;
      stat_clr <= accept & is_eob;
    end
  end

  assign sc_stat_sym_cnt = sym_cnt;
  assign sc_stat_ent_cnt = ent_cnt;
`endif

endmodule

// File: tb/tb_cr_huf_comp_sc.sv
// Directed bench for cr_huf_comp_sc: collapsing, saturation, dual push, backpressure, reset and stats.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cr_huf_comp_sc;
  import cr_huf_compPKG::*;

  localparam int WW = $bits(sc_word_t);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_vld = 1'b0;
  logic [9:0]                in_sym = '0;
  logic [0:0]                in_meta = '0;
  logic [SC_SEQID_WIDTH-1:0] in_seq_id = '0;
  e_pipe_eob                 in_eob = MIDDLE;
  logic                      sc_in_rdy;
  logic [3:0]                sc_is_vld;
  logic [9:0]                sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3;
  logic [2:0]                sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3;
  logic [0:0]                sc_is_meta;
  logic [SC_SEQID_WIDTH-1:0] sc_is_seq_id;
  e_pipe_eob                 sc_is_eob;
  logic                      sc_is_not_empty;
  logic                      is_sc_rd = 1'b0;
`ifdef CR_HUF_COMP_SC_STATS_EN
  logic [19:0]               sc_stat_sym_cnt;
  logic [15:0]               sc_stat_ent_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WW-1:0] exp_q[$];

  cr_huf_comp_sc dut (
    .clk             (clk),
    .rst             (rst),
    .in_vld          (in_vld),
    .in_sym          (in_sym),
    .in_meta         (in_meta),
    .in_seq_id       (in_seq_id),
    .in_eob          (in_eob),
    .sc_in_rdy       (sc_in_rdy),
    .sc_is_vld       (sc_is_vld),
    .sc_is_sym0      (sc_is_sym0),
    .sc_is_sym1      (sc_is_sym1),
    .sc_is_sym2      (sc_is_sym2),
    .sc_is_sym3      (sc_is_sym3),
    .sc_is_cnt0      (sc_is_cnt0),
    .sc_is_cnt1      (sc_is_cnt1),
    .sc_is_cnt2      (sc_is_cnt2),
    .sc_is_cnt3      (sc_is_cnt3),
    .sc_is_meta      (sc_is_meta),
    .sc_is_seq_id    (sc_is_seq_id),
    .sc_is_eob       (sc_is_eob),
    .sc_is_not_empty (sc_is_not_empty),
    .is_sc_rd        (is_sc_rd)
`ifdef CR_HUF_COMP_SC_STATS_EN
    ,
    .sc_stat_sym_cnt (sc_stat_sym_cnt),
    .sc_stat_ent_cnt (sc_stat_ent_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [WW-1:0] obs_word();
    sc_word_t w;
    w.vld            = sc_is_vld;
    w.entry[0].sym   = sc_is_sym0;
    w.entry[0].cnt   = sc_is_cnt0;
    w.entry[1].sym   = sc_is_sym1;
    w.entry[1].cnt   = sc_is_cnt1;
    w.entry[2].sym   = sc_is_sym2;
    w.entry[2].cnt   = sc_is_cnt2;
    w.entry[3].sym   = sc_is_sym3;
    w.entry[3].cnt   = sc_is_cnt3;
    w.meta           = sc_is_meta;
    w.seq_id         = sc_is_seq_id;
    w.eob            = sc_is_eob;
    return w;
  endfunction

  function automatic logic [WW-1:0] exp_word(input logic [3:0] v,
                                             input logic [9:0] s0, input logic [2:0] c0,
                                             input logic [9:0] s1, input logic [2:0] c1,
                                             input logic [9:0] s2, input logic [2:0] c2,
                                             input logic [9:0] s3, input logic [2:0] c3,
                                             input logic [0:0] m,
                                             input logic [SC_SEQID_WIDTH-1:0] q,
                                             input e_pipe_eob e);
    sc_word_t w;
    w.vld          = v;
    w.entry[0].sym = s0;
    w.entry[0].cnt = c0;
    w.entry[1].sym = s1;
    w.entry[1].cnt = c1;
    w.entry[2].sym = s2;
    w.entry[2].cnt = c2;
    w.entry[3].sym = s3;
    w.entry[3].cnt = c3;
    w.meta         = m;
    w.seq_id       = q;
    w.eob          = e;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the symbol was accepted.
  task automatic send(input logic [9:0] s, input e_pipe_eob e,
                      input logic [0:0] m, input logic [SC_SEQID_WIDTH-1:0] q);
    int t = 0;
    while (!sc_in_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!sc_in_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: sc_in_rdy=%0b required 1 within 100 cycles", sc_in_rdy);
    end
    in_vld    = 1'b1;
    in_sym    = s;
    in_eob    = e;
    in_meta   = m;
    in_seq_id = q;
    @(negedge clk);
    in_vld    = 1'b0;
    in_eob    = MIDDLE;
  endtask

  task automatic pop();
    is_sc_rd = 1'b1;
    @(negedge clk);
    is_sc_rd = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sc_in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy_low: got %0b required 0", sc_in_rdy);
    end
    n_checks++;
    if (sc_is_not_empty !== 1'b0 || obs_word() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: not_empty=%0b word=%h required 0/0", sc_is_not_empty, obs_word());
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sc_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy_after: got %0b required 1", sc_in_rdy);
    end
  endtask

  task automatic test_collapse();
    logic [WW-1:0] e;
    send(10'h0A, MIDDLE, 1'b0, 8'h11);
    send(10'h0A, MIDDLE, 1'b0, 8'h11);
    send(10'h0A, MIDDLE, 1'b0, 8'h11);
    send(10'h0B, MIDDLE, 1'b0, 8'h11);
    send(10'h0C, MIDDLE, 1'b0, 8'h11);
    send(10'h0D, LAST,   1'b0, 8'h11);
    e = exp_word(4'b1111, 10'h0A, 3'd3, 10'h0B, 3'd1, 10'h0C, 3'd1, 10'h0D, 3'd1, 1'b0, 8'h11, LAST);
    n_checks++;
    if (sc_is_not_empty !== 1'b1 || obs_word() !== e) begin
      n_fail++;
      $display("FAIL collapse_word: not_empty=%0b got %h required %h", sc_is_not_empty, obs_word(), e);
    end
    pop();
    n_checks++;
    if (sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL collapse_single_word: not_empty=%0b required 0", sc_is_not_empty);
    end
  endtask

  task automatic test_saturation();
    logic [WW-1:0] e;
    for (int i = 0; i < 9; i++) send(10'h0A, (i == 8) ? LAST : MIDDLE, 1'b1, 8'h22);
    e = exp_word(4'b0011, 10'h0A, 3'd7, 10'h0A, 3'd2, 10'h0, 3'd0, 10'h0, 3'd0, 1'b1, 8'h22, LAST);
    n_checks++;
    if (obs_word() !== e) begin
      n_fail++;
      $display("FAIL saturation_word: got %h required %h", obs_word(), e);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] e;
    // Tags of the first symbol must stick to every word of the block.
    send(10'h0A, MIDDLE, 1'b1, 8'h05);
    send(10'h0B, MIDDLE, 1'b0, 8'h09);
    send(10'h0C, MIDDLE, 1'b0, 8'h09);
    send(10'h0D, MIDDLE, 1'b0, 8'h09);
    send(10'h0E, LAST,   1'b0, 8'h09);
    e = exp_word(4'b1111, 10'h0A, 3'd1, 10'h0B, 3'd1, 10'h0C, 3'd1, 10'h0D, 3'd1, 1'b1, 8'h05, MIDDLE);
    n_checks++;
    if (sc_is_not_empty !== 1'b1 || obs_word() !== e) begin
      n_fail++;
      $display("FAIL b2b_word1: not_empty=%0b got %h required %h", sc_is_not_empty, obs_word(), e);
    end
    pop();
    e = exp_word(4'b0001, 10'h0E, 3'd1, 10'h0, 3'd0, 10'h0, 3'd0, 10'h0, 3'd0, 1'b1, 8'h05, LAST);
    n_checks++;
    if (sc_is_not_empty !== 1'b1 || obs_word() !== e) begin
      n_fail++;
      $display("FAIL b2b_word2: not_empty=%0b got %h required %h", sc_is_not_empty, obs_word(), e);
    end
    pop();
    n_checks++;
    if (sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: not_empty=%0b required 0", sc_is_not_empty);
    end
  endtask

  task automatic test_push_pop_empty();
    logic [WW-1:0] e;
    is_sc_rd = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_empty_ignored: not_empty=%0b required 0", sc_is_not_empty);
    end
    send(10'h07, PASS_LAST, 1'b0, 8'h33);
    e = exp_word(4'b0001, 10'h07, 3'd1, 10'h0, 3'd0, 10'h0, 3'd0, 10'h0, 3'd0, 1'b0, 8'h33, PASS_LAST);
    n_checks++;
    if (sc_is_not_empty !== 1'b1 || obs_word() !== e) begin
      n_fail++;
      $display("FAIL push_into_empty: not_empty=%0b got %h required %h", sc_is_not_empty, obs_word(), e);
    end
    @(negedge clk);
    is_sc_rd = 1'b0;
    n_checks++;
    if (sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_after_push: not_empty=%0b required 0", sc_is_not_empty);
    end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] got;
    logic [9:0]    b;
    for (int i = 0; i < 13; i++) send(10'(10 + i), MIDDLE, 1'b0, 8'h03);
    for (int w = 0; w < 3; w++) begin
      b = 10'(10 + 4 * w);
      exp_q.push_back(exp_word(4'b1111, b, 3'd1, b + 10'd1, 3'd1, b + 10'd2, 3'd1,
                               b + 10'd3, 3'd1, 1'b0, 8'h03, MIDDLE));
    end
    n_checks++;
    if (sc_in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_rdy_drop: got %0b required 0", sc_in_rdy);
    end
    // A symbol offered while stalled must not be taken.
    in_vld = 1'b1;
    in_sym = 10'h3FF;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (sc_in_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_rdy_held: got %0b required 0", sc_in_rdy);
      end
    end
    in_vld = 1'b0;
    got = obs_word();
    n_checks++;
    if (got !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_word: got %h required %h", got, exp_q[0]);
    end
    void'(exp_q.pop_front());
    pop();
    send(10'(23), LAST, 1'b0, 8'h03);
    exp_q.push_back(exp_word(4'b0011, 10'd22, 3'd1, 10'd23, 3'd1, 10'h0, 3'd0, 10'h0, 3'd0,
                             1'b0, 8'h03, LAST));
    while (exp_q.size() > 0) begin
      got = obs_word();
      n_checks++;
      if (sc_is_not_empty !== 1'b1 || got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL bp_word: not_empty=%0b got %h required %h", sc_is_not_empty, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop();
    end
    n_checks++;
    if (sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: not_empty=%0b required 0", sc_is_not_empty);
    end
  endtask

  task automatic test_reset_mid_block();
    logic [WW-1:0] e;
    send(10'h01, MIDDLE, 1'b1, 8'h44);
    send(10'h02, MIDDLE, 1'b1, 8'h44);
    send(10'h03, MIDDLE, 1'b1, 8'h44);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sc_in_rdy !== 1'b0 || sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_during: rdy=%0b not_empty=%0b required 0/0", sc_in_rdy, sc_is_not_empty);
    end
    rst = 1'b0;
    @(negedge clk);
    send(10'h58, LAST, 1'b0, 8'h55);
    e = exp_word(4'b0001, 10'h58, 3'd1, 10'h0, 3'd0, 10'h0, 3'd0, 10'h0, 3'd0, 1'b0, 8'h55, LAST);
    n_checks++;
    if (obs_word() !== e) begin
      n_fail++;
      $display("FAIL midrst_word: got %h required %h", obs_word(), e);
    end
    pop();
    n_checks++;
    if (sc_is_not_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_stale: not_empty=%0b required 0", sc_is_not_empty);
    end
  endtask

`ifdef CR_HUF_COMP_SC_STATS_EN
  task automatic test_stats();
    int runs[6] = '{3, 4, 2, 5, 3, 3};
    int k = 0;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < runs[r]; j++) begin
        k++;
        send(10'(r + 1), (k == 20) ? LAST : MIDDLE, 1'b0, 8'h66);
      end
    end
    n_checks++;
    if (sc_stat_sym_cnt !== 20'd20 || sc_stat_ent_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL stats_at_eob: sym=%0d ent=%0d required 20/6", sc_stat_sym_cnt, sc_stat_ent_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (sc_stat_sym_cnt !== 20'd0 || sc_stat_ent_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_cleared: sym=%0d ent=%0d required 0/0", sc_stat_sym_cnt, sc_stat_ent_cnt);
    end
    pop();
    pop();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_collapse();
    test_saturation();
    test_back_to_back();
    test_push_pop_empty();
    test_backpressure();
    test_reset_mid_block();
`ifdef CR_HUF_COMP_SC_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
